aes128_word_loader: RTL and testbench
=====================================

// Module: aes128_word_loader
// PURPOSE
//  Stream front/back end for the AES-128 encryption core. Packs 32-bit input words into the
//  core's 128-bit key and plaintext operands, pulses the core's start, and waits for its
//  end-of-encryption flag. Captures the 128-bit ciphertext and drains it as four 32-bit words
//  under valid/ready. The key is retained across blocks, so only plaintext need be re-sent.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in WAIT before abort; 0 disables timeout
//  TIMEOUT_W       8    width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  pi_clk          in   1    clock; all logic on rising edge
//  pi_rst_n        in   1    reset, synchronous, active-low
//  pi_word         in   32   input word (key or plaintext)
//  pi_word_is_key  in   1    1: pi_word is key material; 0: plaintext
//  pi_word_valid   in   1    input word valid
//  po_word_ready   out  1    input word accepted when valid&ready
//  po_core_key     out  128  key operand to core, held stable START..CAPTURE
//  po_core_data    out  128  plaintext operand to core, held stable START..CAPTURE
//  po_core_start   out  1    one-cycle start pulse to core
//  pi_core_done    in   1    core end-of-encryption pulse
//  pi_core_result  in   128  core output register (valid the cycle after pi_core_done)
//  po_out_word     out  32   ciphertext word
//  po_out_valid    out  1    ciphertext word valid
//  pi_out_ready    in   1    downstream accepts when valid&ready
//  po_busy         out  1    high in START/WAIT/CAPTURE/DRAIN
//  po_err          out  1    one-cycle pulse on protocol error or timeout
// BEHAVIOUR
//  Reset (pi_rst_n=0 at edge): state LOAD, word count 0, key_valid 0, key/data/out regs 0.
//   All outputs 0 except po_word_ready=1. Reset mid-operation aborts; the core is reset by the same net.
//  Word order: first accepted word = bits [127:96], fourth = [31:0] (FIPS-197 byte order).
//  FSM:
//   LOAD: po_word_ready=1; each accepted word shifts into the group buffer and count++.
//     The group type is latched from the first word's pi_word_is_key.
//     A word whose is_key differs from the in-progress group pulses po_err, discards the
//      partial group, and becomes word 0 of a new group.
//     4th key word: copy to key reg, set key_valid, stay in LOAD.
//     4th data word: if key_valid, copy to data reg and go to START.
//      Else pulse po_err, discard the block, stay in LOAD.
//   START: po_core_start=1 for exactly one cycle, then WAIT; po_word_ready=0.
//   WAIT: counts cycles. On pi_core_done, go to CAPTURE.
//     If the count reaches TIMEOUT_CYCLES (nonzero) without done, pulse po_err and return to LOAD.
//   CAPTURE: register pi_core_result into out buffer; word index 0; go to DRAIN.
//   DRAIN: po_out_valid=1, po_out_word=out buffer word[idx] (MSW first).
//     On valid&ready, idx++; after the 4th handshake, go to LOAD.
//     po_out_word must be stable while valid&!ready.
//  Latency: last plaintext word accepted at cycle N -> start at N+1.
//   First output valid 2 cycles after the done pulse.
//  pi_core_done outside WAIT is ignored. Input words are not accepted outside LOAD (no overlap).
//  Counters: word count 2-bit wraps 3->0 at group completion; timeout counter saturates.
// STRUCTURE
//  Package aes128_stream_pkg: WORD_W=32, WORDS_PER_BLOCK=4, FSM state encoding
//   (LOAD, START, WAIT, CAPTURE, DRAIN).
//  One sub-module: aes128_word_serializer (128-bit buffer + 2-bit index + valid/ready drain).
//  The top level that pairs this with the core drives core reset as ~pi_rst_n.
// TESTING
//  1 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff
//    -> out words 69c4e0d8,6a7b0430,d8cdb780,70b4c55a; one start pulse.
//  2 Key retention: second pt 00112233445566778899aabbccddeeff with no key resend
//    -> same four ciphertext words.
//  3 Data before any key: 4 data words after reset -> po_err pulse, no po_core_start, ready stays 1.
//  4 Mixed group: 2 key words then 1 data word -> po_err on 3rd accept.
//    Subsequent 3 data words plus prior key complete the block correctly.
//  5 Backpressure: pi_out_ready toggles 1,0,0,1,... in DRAIN -> words held stable, order preserved,
//    exactly 4 handshakes.
//  6 Timeout/reset: hold pi_core_done=0 -> po_err at TIMEOUT_CYCLES, back to LOAD.
//    Assert pi_rst_n=0 in DRAIN -> next cycle all outputs at reset values, key_valid cleared.

Source files
------------

// File: rtl/aes128_stream_pkg.sv
// Shared widths and FSM state encoding for the AES-128 word loader and its output serializer.
// Pure declarations: no logic, so no latency or backpressure of its own.
package aes128_stream_pkg;
   localparam int WORD_W          = 32;
   localparam int WORDS_PER_BLOCK = 4;
   localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;

   typedef enum logic [2:0] {
      ST_LOAD    = 3'd0,
      ST_START   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DRAIN   = 3'd4
   } state_e;
endpackage

// File: rtl/aes128_word_serializer.sv
// Drains a captured 128-bit block as four 32-bit words, MSW first; valid the cycle after load_i.
// Backpressure: the current word is held while valid_o & !ready_i; last_o marks the final handshake.
module aes128_word_serializer
   import aes128_stream_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               load_i,
   input  logic [BLOCK_W-1:0] data_i,
   input  logic               ready_i,
   output logic [WORD_W-1:0]  word_o,
   output logic               valid_o,
   output logic               last_o
);
   localparam logic [1:0] IDX_LAST = 2'(WORDS_PER_BLOCK - 1);

   logic [BLOCK_W-1:0] shreg_q;
   logic [1:0]         idx_q;
   logic               valid_q;
   logic               hs;

   assign hs = valid_q & ready_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         shreg_q <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         shreg_q <= data_i;
         idx_q   <= '0;
         valid_q <= 1'b1;
      end else if (hs) begin
         idx_q <= idx_q + 2'd1;
         if (idx_q == IDX_LAST) valid_q <= 1'b0;
      end
   end

   // Word is forced to zero when idle so the port reads 0 outside DRAIN.
   assign word_o  = valid_q ? shreg_q[BLOCK_W-1 - WORD_W*int'(idx_q) -: WORD_W] : '0;
   assign valid_o = valid_q;
   assign last_o  = hs && (idx_q == IDX_LAST);
endmodule

// File: rtl/aes128_word_loader.sv
// Packs 32-bit words into AES-128 key/plaintext, starts the core (start 1 cycle after last word),
// and drains the ciphertext (first word 2 cycles after done); input stalls outside LOAD, output holds while !ready.
module aes128_word_loader
   import aes128_stream_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMEOUT_W      = 8
) (
   input  logic               pi_clk,
   input  logic               pi_rst_n,
   input  logic [WORD_W-1:0]  pi_word,
   input  logic               pi_word_is_key,
   input  logic               pi_word_valid,
   output logic               po_word_ready,
   output logic [BLOCK_W-1:0] po_core_key,
   output logic [BLOCK_W-1:0] po_core_data,
   output logic               po_core_start,
   input  logic               pi_core_done,
   input  logic [BLOCK_W-1:0] pi_core_result,
   output logic [WORD_W-1:0]  po_out_word,
   output logic               po_out_valid,
   input  logic               pi_out_ready,
   output logic               po_busy,
   output logic               po_err
);
   localparam int                   GRP_W   = BLOCK_W - WORD_W;
   localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   state_e               state_q;
   logic [1:0]           cnt_q;
   logic                 grp_key_q;
   logic                 key_valid_q;
   logic [GRP_W-1:0]     grp_q;
   logic [BLOCK_W-1:0]   key_q;
   logic [BLOCK_W-1:0]   data_q;
   logic [TIMEOUT_W-1:0] to_cnt_q;
   logic                 start_q;
   logic                 err_q;

   logic [BLOCK_W-1:0]   grp_d;
   logic                 accept;
   logic                 mismatch;
   logic                 ser_last;

   // Only three words need buffering; the fourth completes the block straight from the port.
   assign grp_d    = {grp_q, pi_word};
   assign accept   = pi_word_valid && (state_q == ST_LOAD);
   assign mismatch = (cnt_q != 2'd0) && (pi_word_is_key != grp_key_q);

   always_ff @(posedge pi_clk) begin
      if (!pi_rst_n) begin
         state_q     <= ST_LOAD;
         cnt_q       <= '0;
         grp_key_q   <= 1'b0;
         key_valid_q <= 1'b0;
         grp_q       <= '0;
         key_q       <= '0;
         data_q      <= '0;
         to_cnt_q    <= '0;
         start_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         start_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            ST_LOAD: begin
               if (accept) begin
                  if (mismatch) begin
                     err_q     <= 1'b1;
                     grp_q     <= {{(GRP_W-WORD_W){1'b0}}, pi_word};
                     cnt_q     <= 2'd1;
                     grp_key_q <= pi_word_is_key;
                  end else if (cnt_q == 2'd3) begin
                     cnt_q <= 2'd0;
                     if (grp_key_q) begin
                        key_q       <= grp_d;
                        key_valid_q <= 1'b1;
                     end else if (key_valid_q) begin
                        data_q  <= grp_d;
                        start_q <= 1'b1;
                        state_q <= ST_START;
                     end else begin
                        err_q <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + 2'd1;
                     grp_q <= grp_d[GRP_W-1:0];
                     if (cnt_q == 2'd0) grp_key_q <= pi_word_is_key;
                  end
               end
            end
            ST_START: begin
               to_cnt_q <= '0;
               state_q  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (pi_core_done) begin
                  state_q <= ST_CAPTURE;
               end else if ((TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LAST)) begin
                  err_q   <= 1'b1;
                  state_q <= ST_LOAD;
               end else if (to_cnt_q != '1) begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
            end
            ST_CAPTURE: state_q <= ST_DRAIN;
            ST_DRAIN:   if (ser_last) state_q <= ST_LOAD;
            default:    state_q <= ST_LOAD;
         endcase
      end
   end

   aes128_word_serializer u_ser (
      .clk_i   (pi_clk),
      .rst_ni  (pi_rst_n),
      .load_i  (state_q == ST_CAPTURE),
      .data_i  (pi_core_result),
      .ready_i (pi_out_ready),
      .word_o  (po_out_word),
      .valid_o (po_out_valid),
      .last_o  (ser_last)
   );

   assign po_word_ready = (state_q == ST_LOAD);
   assign po_busy       = (state_q != ST_LOAD);
   assign po_core_key   = key_q;
   assign po_core_data  = data_q;
   assign po_core_start = start_q;
   assign po_err        = err_q;
endmodule

// File: tb/tb_aes128_word_loader.sv
// Directed + randomized bench for aes128_word_loader; the AES core is stood in for by the bench,
// which answers each start with a chosen result and checks the serialized words against it.
module tb_aes128_word_loader;
   localparam int TO = 255;

   logic         pi_clk = 1'b0;
   logic         pi_rst_n;
   logic [31:0]  pi_word;
   logic         pi_word_is_key;
   logic         pi_word_valid;
   logic         po_word_ready;
   logic [127:0] po_core_key;
   logic [127:0] po_core_data;
   logic         po_core_start;
   logic         pi_core_done;
   logic [127:0] pi_core_result;
   logic [31:0]  po_out_word;
   logic         po_out_valid;
   logic         pi_out_ready;
   logic         po_busy;
   logic         po_err;

   int n_cmp = 0;
   int n_bad = 0;

   aes128_word_loader #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(8)) dut (
      .pi_clk        (pi_clk),
      .pi_rst_n      (pi_rst_n),
      .pi_word       (pi_word),
      .pi_word_is_key(pi_word_is_key),
      .pi_word_valid (pi_word_valid),
      .po_word_ready (po_word_ready),
      .po_core_key   (po_core_key),
      .po_core_data  (po_core_data),
      .po_core_start (po_core_start),
      .pi_core_done  (pi_core_done),
      .pi_core_result(pi_core_result),
      .po_out_word   (po_out_word),
      .po_out_valid  (po_out_valid),
      .pi_out_ready  (pi_out_ready),
      .po_busy       (po_busy),
      .po_err        (po_err)
   );

   always #5 pi_clk = ~pi_clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, po_word_ready, 1);
      chk({tag, "_start"}, po_core_start, 0);
      chk({tag, "_err"},   po_err, 0);
      chk({tag, "_valid"}, po_out_valid, 0);
      chk({tag, "_busy"},  po_busy, 0);
      chk({tag, "_key"},   po_core_key, 0);
      chk({tag, "_data"},  po_core_data, 0);
      chk({tag, "_word"},  po_out_word, 0);
   endtask

   // All steps begin and end at a falling edge; one word is offered per cycle.
   task automatic send_word(input logic [31:0] w, input logic k,
                            output logic err_o, output logic start_o);
      chk("ready_before_word", po_word_ready, 1);
      pi_word = w; pi_word_is_key = k; pi_word_valid = 1'b1;
      @(negedge pi_clk);
      err_o = po_err; start_o = po_core_start;
      pi_word_valid = 1'b0;
   endtask

   task automatic send_group(input logic [127:0] v, input logic k,
                             output logic err_early, output logic err_last, output logic start_last);
      logic e, s;
      err_early = 1'b0; err_last = 1'b0; start_last = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send_word(v[127-32*i -: 32], k, e, s);
         if (i < 3) err_early = err_early | e | s;
         else begin err_last = e; start_last = s; end
      end
   endtask

   // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready
   task automatic drain(input logic [127:0] r, input int mode);
      int got = 0;
      logic stall = 1'b0;
      logic [31:0] held = '0;
      logic rdy;
      logic [3:0] pat = 4'b1001;
      for (int c = 0; c < 200 && got < 4; c++) begin
         if (c > 0) @(negedge pi_clk);
         if (stall) begin
            chk("held_valid", po_out_valid, 1);
            chk("held_word", po_out_word, held);
         end
         rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[3 - (c % 4)] : 1'($urandom_range(0, 1));
         pi_out_ready = rdy;
         stall = 1'b0;
         if (po_out_valid) begin
            if (rdy) begin
               chk($sformatf("out_word%0d", got), po_out_word, r[127-32*got -: 32]);
               got++;
            end else begin
               stall = 1'b1;
               held = po_out_word;
            end
         end
      end
      chk("handshake_count", got, 4);
      pi_out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge pi_clk);
         chk("post_drain_valid", po_out_valid, 0);
      end
      chk("post_drain_ready", po_word_ready, 1);
      chk("post_drain_busy", po_busy, 0);
   endtask

   // Called right after the start pulse was seen; plays the core and collects the output.
   task automatic run_block(input logic [127:0] exp_key, input logic [127:0] exp_data,
                            input logic [127:0] r, input int dly, input int mode);
      @(negedge pi_clk);
      chk("start_one_cycle", po_core_start, 0);
      chk("busy_in_wait", po_busy, 1);
      chk("ready_low_in_wait", po_word_ready, 0);
      repeat (dly) @(negedge pi_clk);
      chk("core_key", po_core_key, exp_key);
      chk("core_data", po_core_data, exp_data);
      pi_core_done = 1'b1;
      @(negedge pi_clk);
      pi_core_done = 1'b0;
      pi_core_result = r;
      chk("valid_in_capture", po_out_valid, 0);
      @(negedge pi_clk);
      pi_core_result = {$urandom, $urandom, $urandom, $urandom};
      chk("first_valid_latency", po_out_valid, 1);
      drain(r, mode);
   endtask

   initial begin
      logic [127:0] fips_key, fips_pt, fips_ct, exp_key, pt, r;
      logic ee, el, sl, e, s;
      int cycles;
      fips_key = 128'h000102030405060708090a0b0c0d0e0f;
      fips_pt  = 128'h00112233445566778899aabbccddeeff;
      fips_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

      pi_rst_n = 1'b0; pi_word = '0; pi_word_is_key = 1'b0; pi_word_valid = 1'b0;
      pi_core_done = 1'b0; pi_core_result = '0; pi_out_ready = 1'b0;
      repeat (3) @(negedge pi_clk);
      chk_reset_outputs("reset");
      pi_rst_n = 1'b1;
      @(negedge pi_clk);

      // Plaintext with no key loaded is rejected
      send_group({$urandom, $urandom, $urandom, $urandom}, 1'b0, ee, el, sl);
      chk("nokey_early_err", ee, 0);
      chk("nokey_err", el, 1);
      chk("nokey_no_start", sl, 0);
      @(negedge pi_clk);
      chk("nokey_err_pulse", po_err, 0);
      chk("nokey_start", po_core_start, 0);
      chk("nokey_ready", po_word_ready, 1);

      // FIPS-197 C.1
      send_group(fips_key, 1'b1, ee, el, sl);
      exp_key = fips_key;
      chk("key_load_err", ee | el | sl, 0);
      chk("key_load_ready", po_word_ready, 1);
      send_group(fips_pt, 1'b0, ee, el, sl);
      chk("fips_start", sl, 1);
      chk("fips_err", ee | el, 0);
      run_block(exp_key, fips_pt, fips_ct, 2, 0);

      // Key retained: plaintext only
      send_group(fips_pt, 1'b0, ee, el, sl);
      chk("retain_start", sl, 1);
      run_block(exp_key, fips_pt, fips_ct, 0, 0);

      // Mixed group: partial key discarded, data word restarts the group
      pt = {$urandom, $urandom, $urandom, $urandom};
      send_word($urandom, 1'b1, e, s);
      chk("mixed_k0_err", e, 0);
      send_word($urandom, 1'b1, e, s);
      chk("mixed_k1_err", e, 0);
      send_word(pt[127:96], 1'b0, e, s);
      chk("mixed_err", e, 1);
      chk("mixed_no_start", s, 0);
      send_word(pt[95:64], 1'b0, e, s);
      send_word(pt[63:32], 1'b0, e, s);
      send_word(pt[31:0], 1'b0, e, s);
      chk("mixed_start", s, 1);
      r = {$urandom, $urandom, $urandom, $urandom};
      run_block(exp_key, pt, r, 1, 0);

      // Backpressure pattern
      pt = {$urandom, $urandom, $urandom, $urandom};
      send_group(pt, 1'b0, ee, el, sl);
      chk("bp_start", sl, 1);
      r = {$urandom, $urandom, $urandom, $urandom};
      run_block(exp_key, pt, r, 3, 1);

      // Randomized blocks, occasional key change
      for (int n = 0; n < 8; n++) begin
         if ($urandom_range(0, 1) == 1) begin
            exp_key = {$urandom, $urandom, $urandom, $urandom};
            send_group(exp_key, 1'b1, ee, el, sl);
            chk("rnd_key_err", ee | el | sl, 0);
         end
         pt = {$urandom, $urandom, $urandom, $urandom};
         send_group(pt, 1'b0, ee, el, sl);
         chk("rnd_start", sl, 1);
         r = {$urandom, $urandom, $urandom, $urandom};
         run_block(exp_key, pt, r, $urandom_range(0, 6), 2);
      end

      // Timeout: start cycle, then TO cycles of WAIT, then the error pulse
      pt = {$urandom, $urandom, $urandom, $urandom};
      send_group(pt, 1'b0, ee, el, sl);
      chk("to_start", sl, 1);
      cycles = 0;
      while (po_err !== 1'b1 && cycles < 400) begin
         @(negedge pi_clk);
         cycles++;
      end
      chk("timeout_cycles", cycles, TO + 1);
      @(negedge pi_clk);
      chk("timeout_err_pulse", po_err, 0);
      chk("timeout_ready", po_word_ready, 1);
      chk("timeout_busy", po_busy, 0);
      pi_core_done = 1'b1;
      @(negedge pi_clk);
      pi_core_done = 1'b0;
      @(negedge pi_clk);
      chk("stray_done_busy", po_busy, 0);
      chk("stray_done_valid", po_out_valid, 0);

      // Reset while draining
      send_group(pt, 1'b0, ee, el, sl);
      chk("rst_start", sl, 1);
      @(negedge pi_clk);
      pi_core_done = 1'b1;
      @(negedge pi_clk);
      pi_core_done = 1'b0;
      pi_core_result = {$urandom, $urandom, $urandom, $urandom};
      pi_out_ready = 1'b0;
      @(negedge pi_clk);
      chk("rst_in_drain_valid", po_out_valid, 1);
      pi_rst_n = 1'b0;
      @(negedge pi_clk);
      chk_reset_outputs("drain_reset");
      pi_rst_n = 1'b1;
      pi_core_result = '0;
      @(negedge pi_clk);
      send_group(pt, 1'b0, ee, el, sl);
      chk("rst_key_cleared_err", el, 1);
      chk("rst_key_cleared_start", sl, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
